// File: rtl/mhp_rx_parser.sv
// mhp_rx_parser: receive-side MHP frame parser.
// Pulls bytes from the eth RX FIFO one at a time, decodes the MHP header,
// buffers the payload, checks the 16-bit sum, filters on destination and
// holds a good frame for the command handler until it is acknowledged.
`timescale 1ns/1ps
module mhp_rx_parser #(
   parameter logic [15:0] MY_ADDR      = 16'h0001,
   parameter int          MAX_PAYLOAD  = 64,
   parameter int          IDLE_TIMEOUT = 62
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_rdata,
   input  logic        i_rready,
   output logic        o_rreq,
   output logic        o_frame_valid,
   output logic        o_frame_err,
   output logic [1:0]  o_err_code,
   output logic [15:0] o_dst,
   output logic [15:0] o_src,
   output logic [15:0] o_size,
   output logic [6:0]  o_type,
   output logic        o_direction,
   input  logic [7:0]  i_pl_addr,
   output logic [7:0]  o_pl_data,
   input  logic        i_frame_ack
);

   localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
   localparam int TW = $clog2(IDLE_TIMEOUT + 1);

   localparam logic [1:0] ERR_CS    = 2'd1;
   localparam logic [1:0] ERR_TRUNC = 2'd2;
   localparam logic [1:0] ERR_OVER  = 2'd3;

   // WAIT/CAPTURE form the byte fetch handshake; the phase says what the
   // captured byte means.
   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_CAPTURE, S_CHECK, S_HOLD
   } state_t;

   typedef enum logic [1:0] {
      P_HDR, P_PAYLOAD, P_CS, P_DRAIN
   } phase_t;

   state_t state_q, state_d;
   phase_t phase_q, phase_d;

   logic [15:0]   cnt_q;
   logic [TW-1:0] tmo_q;
   logic [15:0]   sum_q;
   logic [15:0]   scs_q;
   logic [7:0]    dtype_q;
   logic          good_q;
   logic          err_pend_q;
   logic [1:0]    pend_code_q;

   logic [7:0]    pl_mem [MAX_PAYLOAD];

   logic          rreq_c;
   logic          tmo_hit;
   logic          hdr_last;
   logic          pl_last;
   logic          cs_last;
   logic          oversize;
   logic          dst_ok;
   logic          pl_wr;
   logic [AW-1:0] pl_rd_idx;
   logic          pl_addr_unused;

   // Upper address bits are don't-care when the buffer is smaller than 256.
   assign pl_rd_idx      = i_pl_addr[AW-1:0];
   assign pl_addr_unused = ^i_pl_addr;

   assign tmo_hit  = (tmo_q == TW'(IDLE_TIMEOUT - 1));
   assign hdr_last = (cnt_q == 16'd6);
   assign pl_last  = ((cnt_q + 16'd1) == o_size);
   assign cs_last  = (cnt_q == 16'd1);
   assign oversize = (o_size > 16'(MAX_PAYLOAD));
   assign dst_ok   = (o_dst == MY_ADDR) || (o_dst == 16'hFFFF);
   assign pl_wr    = (state_q == S_CAPTURE) && (phase_q == P_PAYLOAD);

   assign o_type      = dtype_q[6:0];
   assign o_direction = dtype_q[7];
   // Pop request is combinational so the byte lands in the CAPTURE cycle;
   // it is masked during reset so every output reads 0 while i_rst is high.
   assign o_rreq      = rreq_c & ~i_rst;

   // State and phase registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         phase_q <= P_HDR;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
      end
   end

   // Next state, next phase and the fetch request.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      rreq_c  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (i_rready) begin
               rreq_c  = 1'b1;
               state_d = S_CAPTURE;
               phase_d = P_HDR;
            end
         end
         S_WAIT: begin
            if (i_rready) begin
               rreq_c  = 1'b1;
               state_d = S_CAPTURE;
            end else if (tmo_hit) begin
               state_d = (phase_q == P_DRAIN && good_q) ? S_HOLD : S_IDLE;
            end
         end
         S_CAPTURE: begin
            state_d = S_WAIT;
            unique case (phase_q)
               P_HDR: begin
                  if (hdr_last) begin
                     if (oversize)             phase_d = P_DRAIN;
                     else if (o_size == 16'd0) phase_d = P_CS;
                     else                      phase_d = P_PAYLOAD;
                  end
               end
               P_PAYLOAD: begin
                  if (pl_last) phase_d = P_CS;
               end
               P_CS: begin
                  if (cs_last) state_d = S_CHECK;
               end
               default: ;
            endcase
         end
         S_CHECK: begin
            state_d = S_WAIT;
            phase_d = P_DRAIN;
         end
         S_HOLD: begin
            if (i_frame_ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: byte counter, timeout, sum, header fields and frame verdict.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q         <= '0;
         tmo_q         <= '0;
         sum_q         <= '0;
         scs_q         <= '0;
         o_dst         <= '0;
         o_src         <= '0;
         o_size        <= '0;
         dtype_q       <= '0;
         good_q        <= 1'b0;
         err_pend_q    <= 1'b0;
         pend_code_q   <= '0;
         o_frame_valid <= 1'b0;
         o_frame_err   <= 1'b0;
         o_err_code    <= '0;
      end else begin
         o_frame_err <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               cnt_q      <= '0;
               tmo_q      <= '0;
               sum_q      <= '0;
               good_q     <= 1'b0;
               err_pend_q <= 1'b0;
            end
            S_WAIT: begin
               if (i_rready) begin
                  tmo_q <= '0;
               end else if (tmo_hit) begin
                  tmo_q <= '0;
                  if (phase_q != P_DRAIN) begin
                     o_frame_err <= 1'b1;
                     o_err_code  <= ERR_TRUNC;
                  end else if (good_q) begin
                     o_frame_valid <= 1'b1;
                  end else if (err_pend_q) begin
                     o_frame_err <= 1'b1;
                     o_err_code  <= pend_code_q;
                  end
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            S_CAPTURE: begin
               unique case (phase_q)
                  P_HDR: begin
                     sum_q <= sum_q + {8'd0, i_rdata};
                     case (cnt_q[2:0])
                        3'd0:    o_dst[15:8]  <= i_rdata;
                        3'd1:    o_dst[7:0]   <= i_rdata;
                        3'd2:    o_src[15:8]  <= i_rdata;
                        3'd3:    o_src[7:0]   <= i_rdata;
                        3'd4:    o_size[15:8] <= i_rdata;
                        3'd5:    o_size[7:0]  <= i_rdata;
                        default: dtype_q      <= i_rdata;
                     endcase
                     if (hdr_last) begin
                        cnt_q <= '0;
                        if (oversize) begin
                           err_pend_q  <= 1'b1;
                           pend_code_q <= ERR_OVER;
                        end
                     end else begin
                        cnt_q <= cnt_q + 16'd1;
                     end
                  end
                  P_PAYLOAD: begin
                     sum_q <= sum_q + {8'd0, i_rdata};
                     cnt_q <= pl_last ? 16'd0 : cnt_q + 16'd1;
                  end
                  P_CS: begin
                     if (cs_last) begin
                        scs_q[7:0] <= i_rdata;
                        cnt_q      <= '0;
                     end else begin
                        scs_q[15:8] <= i_rdata;
                        cnt_q       <= 16'd1;
                     end
                  end
                  default: ;
               endcase
            end
            S_CHECK: begin
               // A frame for another node is dropped without any report.
               if (dst_ok) begin
                  if (scs_q != sum_q) begin
                     err_pend_q  <= 1'b1;
                     pend_code_q <= ERR_CS;
                  end else begin
                     good_q <= 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (i_frame_ack) o_frame_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Payload buffer write; contents are not reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst && pl_wr) pl_mem[cnt_q[AW-1:0]] <= i_rdata;
   end

   // Registered payload read port, usable in any state.
   always_ff @(posedge i_clk) begin
      if (i_rst) o_pl_data <= '0;
      else       o_pl_data <= pl_mem[pl_rd_idx];
   end

endmodule

// File: tb/tb_mhp_rx_parser.sv
// Directed bench for mhp_rx_parser: a byte-queue FIFO model feeds frames,
// each step checks header fields, error pulses and payload readback.
`timescale 1ns/1ps
module tb_mhp_rx_parser;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [7:0]  i_rdata = 8'h00;
   logic        i_rready = 1'b0;
   logic        o_rreq;
   logic        o_frame_valid;
   logic        o_frame_err;
   logic [1:0]  o_err_code;
   logic [15:0] o_dst;
   logic [15:0] o_src;
   logic [15:0] o_size;
   logic [6:0]  o_type;
   logic        o_direction;
   logic [7:0]  i_pl_addr;
   logic [7:0]  o_pl_data;
   logic        i_frame_ack;

   mhp_rx_parser #(.MY_ADDR(16'h0001), .MAX_PAYLOAD(64), .IDLE_TIMEOUT(62)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_rdata(i_rdata), .i_rready(i_rready),
      .o_rreq(o_rreq), .o_frame_valid(o_frame_valid), .o_frame_err(o_frame_err),
      .o_err_code(o_err_code), .o_dst(o_dst), .o_src(o_src), .o_size(o_size),
      .o_type(o_type), .o_direction(o_direction), .i_pl_addr(i_pl_addr),
      .o_pl_data(o_pl_data), .i_frame_ack(i_frame_ack)
   );

   always #5 i_clk = ~i_clk;

   logic [7:0] fifo [$];
   logic       rdy_en = 1'b1;
   int         pops = 0;

   // RX FIFO model: data appears the cycle after the pop, non-empty is registered.
   always @(posedge i_clk) begin
      if (o_rreq) begin
         pops <= pops + 1;
         if (fifo.size() != 0) i_rdata <= fifo.pop_front();
         else                  i_rdata <= 8'h00;
      end
      i_rready <= rdy_en && (fifo.size() != 0);
   end

   int   err_pulses = 0, valid_rises = 0, bb_viol = 0, hold_viol = 0;
   int   gap2 = 0, gap3 = 0, cyc = 0, last_rq = -100;
   logic [1:0] last_code = 2'd0;
   logic prev_rreq = 1'b0, prev_valid = 1'b0;

   // Output monitor sampled on the falling edge.
   always @(negedge i_clk) begin
      cyc = cyc + 1;
      if (o_frame_err) begin
         err_pulses = err_pulses + 1;
         last_code  = o_err_code;
      end
      if (o_frame_valid && !prev_valid) valid_rises = valid_rises + 1;
      if (o_rreq && prev_rreq) bb_viol = bb_viol + 1;
      if (o_rreq && o_frame_valid) hold_viol = hold_viol + 1;
      if (o_rreq) begin
         if (cyc - last_rq == 2) gap2 = gap2 + 1;
         if (cyc - last_rq == 3) gap3 = gap3 + 1;
         last_rq = cyc;
      end
      prev_rreq  = o_rreq;
      prev_valid = o_frame_valid;
   end

   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge i_clk);
      #1;
   endtask

   task automatic push_vec(input logic [127:0] v, input int n);
      for (int i = 0; i < n; i++) fifo.push_back(v[8*(n-1-i) +: 8]);
   endtask

   task automatic push_pad(input int n);
      for (int i = 0; i < n; i++) fifo.push_back(8'h00);
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 400; i++) begin
         if (o_frame_valid) break;
         step(1);
      end
      chk(tag, o_frame_valid, 1'b1);
   endtask

   task automatic do_ack();
      i_frame_ack = 1'b1;
      step(1);
      i_frame_ack = 1'b0;
      chk("ack_clears_valid", o_frame_valid, 1'b0);
   endtask

   // Frame A: 00 01 00 05 00 02 03 AA BB, sum 0x0B + 0xAA + 0xBB = 0x0170.
   localparam logic [127:0] FRAME_A     = 128'h00_01_00_05_00_02_03_AA_BB_01_70;
   localparam logic [127:0] FRAME_A_BAD = 128'h00_01_00_05_00_02_03_AA_BB_01_72;
   // Broadcast: FF+FF+83 = 0x0281.
   localparam logic [127:0] FRAME_BC    = 128'hFF_FF_00_00_00_00_83_02_81;
   // Other node: 02+05+01+01+55 = 0x005E.
   localparam logic [127:0] FRAME_OTH   = 128'h00_02_00_05_00_01_01_55_00_5E;
   localparam logic [127:0] FRAME_OVR   = 128'h00_01_00_05_00_41_03_11_22_33_44;
   localparam logic [127:0] FRAME_TRN   = 128'h00_01_00_05_00_04_03_11_22;

   int e0, v0, p0, g2, g3;

   initial begin
      i_rst = 1'b1; i_frame_ack = 1'b0; i_pl_addr = 8'd0;
      step(3);
      chk("rst_valid", o_frame_valid, 1'b0);
      chk("rst_err", o_frame_err, 1'b0);
      chk("rst_code", o_err_code, 2'd0);
      chk("rst_hdr", {o_dst, o_src}, 32'd0);
      chk("rst_size", o_size, 16'd0);
      chk("rst_rreq", o_rreq, 1'b0);
      chk("rst_pl", o_pl_data, 8'd0);
      i_rst = 1'b0;

      // Accepted frame with padding.
      g2 = gap2; g3 = gap3; p0 = pops;
      push_vec(FRAME_A, 11); push_pad(8);
      wait_valid("a_valid");
      chk("a_dst", o_dst, 16'h0001);
      chk("a_src", o_src, 16'h0005);
      chk("a_size", o_size, 16'd2);
      chk("a_type", o_type, 7'd3);
      chk("a_dir", o_direction, 1'b0);
      chk("a_pops", pops - p0, 19);
      chk("a_gap2", gap2 - g2, 17);
      chk("a_gap3", gap3 - g3, 1);
      i_pl_addr = 8'd0; step(1);
      chk("a_buf0", o_pl_data, 8'hAA);
      i_pl_addr = 8'd1; step(1);
      chk("a_buf1", o_pl_data, 8'hBB);
      do_ack();

      // Broadcast request, zero payload.
      push_vec(FRAME_BC, 9); push_pad(4);
      wait_valid("bc_valid");
      chk("bc_dst", o_dst, 16'hFFFF);
      chk("bc_type", o_type, 7'd3);
      chk("bc_dir", o_direction, 1'b1);
      chk("bc_size", o_size, 16'd0);
      do_ack();

      // Bad checksum.
      e0 = err_pulses; v0 = valid_rises;
      push_vec(FRAME_A_BAD, 11); push_pad(8);
      step(150);
      chk("cs_pulses", err_pulses - e0, 1);
      chk("cs_code_pulse", last_code, 2'd1);
      chk("cs_code_held", o_err_code, 2'd1);
      chk("cs_no_valid", valid_rises - v0, 0);

      // Wrong address: silent drop, then a good frame still gets through.
      e0 = err_pulses; v0 = valid_rises;
      push_vec(FRAME_OTH, 10); push_pad(6);
      step(150);
      chk("oth_pulses", err_pulses - e0, 0);
      chk("oth_valid", valid_rises - v0, 0);
      push_vec(FRAME_A, 11); push_pad(8);
      wait_valid("oth_next_valid");
      chk("oth_next_dst", o_dst, 16'h0001);
      do_ack();

      // Oversize: error 3 and the buffer keeps frame A's bytes.
      e0 = err_pulses;
      push_vec(FRAME_OVR, 11); push_pad(4);
      step(150);
      chk("ovr_pulses", err_pulses - e0, 1);
      chk("ovr_code", last_code, 2'd3);
      i_pl_addr = 8'd0; step(1);
      chk("ovr_buf0", o_pl_data, 8'hAA);
      i_pl_addr = 8'd1; step(1);
      chk("ovr_buf1", o_pl_data, 8'hBB);

      // Truncated payload.
      e0 = err_pulses;
      push_vec(FRAME_TRN, 9);
      step(120);
      chk("trn_pulses", err_pulses - e0, 1);
      chk("trn_code", last_code, 2'd2);
      chk("trn_code_held", o_err_code, 2'd2);

      // Backpressure: queued frame waits while a frame is held.
      push_vec(FRAME_A, 11); push_pad(8);
      wait_valid("bp_valid");
      push_vec(FRAME_BC, 9); push_pad(4);
      step(20);
      chk("bp_fifo_kept", fifo.size(), 13);
      chk("bp_still_valid", o_frame_valid, 1'b1);
      do_ack();
      wait_valid("bp_next_valid");
      chk("bp_next_dst", o_dst, 16'hFFFF);
      chk("bp_next_dir", o_direction, 1'b1);
      do_ack();

      // Reset in the middle of the payload.
      e0 = err_pulses; v0 = valid_rises; p0 = pops;
      push_vec(FRAME_A, 11); push_pad(8);
      for (int i = 0; i < 100; i++) begin
         if (pops - p0 >= 8) break;
         step(1);
      end
      chk("mid_reached_payload", pops - p0, 8);
      i_rst = 1'b1;
      step(1);
      chk("mid_rst_valid", o_frame_valid, 1'b0);
      chk("mid_rst_err", o_frame_err, 1'b0);
      chk("mid_rst_code", o_err_code, 2'd0);
      chk("mid_rst_dst", o_dst, 16'h0000);
      chk("mid_rst_size", o_size, 16'h0000);
      chk("mid_rst_rreq", o_rreq, 1'b0);
      chk("mid_rst_pl", o_pl_data, 8'h00);
      i_rst = 1'b0;
      // Leftover bytes parse as a frame for node 0xBB01 and are dropped quietly.
      step(150);
      chk("mid_left_pulses", err_pulses - e0, 0);
      chk("mid_left_valid", valid_rises - v0, 0);
      chk("mid_fifo_empty", fifo.size(), 0);

      chk("no_back_to_back_rreq", bb_viol, 0);
      chk("no_rreq_in_hold", hold_viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
